// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: four-mode immediate extender feeding a valid/ready output FIFO
module imm_extend_pipe #(
  parameter int IN_W = 16,
  parameter int OUT_W = 32,
  parameter int BR_SHIFT = 2,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [IN_W-1:0]        in_imm,
  input  logic [1:0]             in_mode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_W-1:0]       out_data,
  output logic [$clog2(DEPTH):0] out_count
);
  localparam int AW = $clog2(DEPTH);
  logic [OUT_W-1:0] mem [DEPTH];
  logic [AW-1:0] wrPtr, rdPtr;
  logic [AW:0] count;
  logic [OUT_W-1:0] zx, sx, ext;
  logic push, pop;
  always_comb begin
    zx = OUT_W'(in_imm);
    sx = OUT_W'($signed(in_imm));
    ext = in_mode[1] ? (in_mode[0] ? sx << BR_SHIFT : zx << (OUT_W - IN_W)) : (in_mode[0] ? sx : zx);
  end
  assign in_ready = (count < (AW+1)'(DEPTH)) & rst_n;
  assign out_valid = count != '0;
  assign out_data = mem[rdPtr];
  assign out_count = count;
  assign push = in_valid & in_ready;
  assign pop = out_valid & out_ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wrPtr] <= ext;
        wrPtr <= wrPtr + AW'(1);
      end
      if (pop) rdPtr <= rdPtr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb_imm_extend_pipe: directed and model-checked stimulus for both default and narrow configurations
module tb_imm_extend_pipe;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  logic inValid = 0, inReady, outValid, outReady = 0;
  logic [15:0] inImm = '0;
  logic [1:0] inMode = '0, outCount;
  logic [31:0] outData;
  logic inValidB = 0, inReadyB, outValidB, outReadyB = 0;
  logic [7:0] inImmB = '0;
  logic [1:0] inModeB = '0;
  logic [15:0] outDataB;
  logic [2:0] outCountB;
  int nVec = 0, nErr = 0;
  logic [31:0] q [$];

  imm_extend_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid), .in_ready(inReady), .in_imm(inImm),
    .in_mode(inMode), .out_valid(outValid), .out_ready(outReady), .out_data(outData),
    .out_count(outCount)
  );
  imm_extend_pipe #(.IN_W(8), .OUT_W(16), .BR_SHIFT(1), .DEPTH(4)) dutB (
    .clk(clk), .rst_n(rst_n), .in_valid(inValidB), .in_ready(inReadyB), .in_imm(inImmB),
    .in_mode(inModeB), .out_valid(outValidB), .out_ready(outReadyB), .out_data(outDataB),
    .out_count(outCountB)
  );

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    nVec++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model(logic [15:0] i, logic [1:0] m);
    case (m)
      2'd0: return {16'h0000, i};
      2'd1: return {{16{i[15]}}, i};
      2'd2: return {i, 16'h0000};
      default: return {{14{i[15]}}, i, 2'b00};
    endcase
  endfunction

  task automatic pass1(string tag, logic [15:0] imm, logic [1:0] mode, logic [31:0] exp);
    inValid = 1; inImm = imm; inMode = mode; outReady = 1;
    tick;
    check({tag, "_v"}, outValid, 1);
    check(tag, outData, exp);
  endtask

  logic [31:0] modeExp [4] = '{32'h00008001, 32'hFFFF8001, 32'h80010000, 32'hFFFE0004};
  logic [15:0] modeExpB [4] = '{16'h0081, 16'hFF81, 16'h8100, 16'hFF02};
  logic [15:0] isoImm [3] = '{16'h0100, 16'h0040, 16'h7FFF};
  logic [1:0] isoMode [3] = '{2'd0, 2'd0, 2'd1};
  logic [31:0] isoExp [3] = '{32'h00000100, 32'h00000040, 32'h00007FFF};

  initial begin
    tick; tick;
    check("rst_rdy", inReady, 0);
    check("rst_vld", outValid, 0);
    check("rst_cnt", outCount, 0);
    check("rst_data", outData, 0);
    check("rstB_rdy", inReadyB, 0);
    rst_n = 1;
    #1;
    check("idle_rdy", inReady, 1);
    check("idle_vld", outValid, 0);
    check("idleB_rdy", inReadyB, 1);

    outReadyB = 1;
    for (int k = 0; k < 4; k++) begin
      inValidB = 1; inImmB = 8'h81; inModeB = 2'(k);
      pass1($sformatf("mode%0d", k), 16'h8001, 2'(k), modeExp[k]);
      check($sformatf("modeB%0d", k), outDataB, modeExpB[k]);
      check($sformatf("modeB%0d_v", k), outValidB, 1);
    end
    inValid = 0; inValidB = 0;
    tick;
    check("drain_vld", outValid, 0);
    check("drainB_cnt", outCountB, 0);

    for (int k = 0; k < 3; k++) pass1($sformatf("iso%0d", k), isoImm[k], isoMode[k], isoExp[k]);
    inValid = 0;
    tick;

    outReady = 0; inValid = 1; inMode = 0;
    inImm = 16'h1111; tick;
    inImm = 16'h2222; tick;
    inImm = 16'h3333; tick;
    check("full_rdy", inReady, 0);
    check("full_cnt", outCount, 2);
    check("full_head", outData, 32'h00001111);
    outReady = 1;
    tick;
    check("pop1_rdy", inReady, 1);
    check("pop1_cnt", outCount, 1);
    check("pop1_head", outData, 32'h00002222);
    tick;
    check("pop2_cnt", outCount, 1);
    check("pop2_head", outData, 32'h00003333);
    inValid = 0;
    tick;
    check("pop3_cnt", outCount, 0);

    begin
      int pushed = 0, cyc = 0;
      while ((pushed < 100 || q.size() != 0) && cyc < 2000) begin
        check("s_cnt", outCount, q.size());
        check("s_rdy", inReady, q.size() < 2);
        inValid = (pushed < 100) && ($urandom_range(0, 3) != 0);
        inImm = 16'($urandom_range(0, 65535));
        inMode = 2'($urandom_range(0, 3));
        outReady = $urandom_range(0, 2) != 0;
        if (outValid && outReady) begin
          if (q.size() == 0) check("s_spurious", outValid, 0);
          else check("s_data", outData, q.pop_front());
        end
        if (inValid && inReady) begin
          q.push_back(model(inImm, inMode));
          pushed++;
        end
        tick;
        cyc++;
      end
      check("s_pushed", pushed, 100);
      check("s_left", q.size(), 0);
    end
    inValid = 0; outReady = 0;
    tick;

    inValid = 1; inMode = 0;
    inImm = 16'hAAAA; tick;
    inImm = 16'hBBBB; tick;
    inValid = 0;
    check("mid_cnt", outCount, 2);
    rst_n = 0;
    #1;
    check("mid_rst_vld", outValid, 0);
    check("mid_rst_cnt", outCount, 0);
    check("mid_rst_rdy", inReady, 0);
    tick;
    rst_n = 1;
    outReady = 1;
    #1;
    check("post_rst_data", outData, 0);
    for (int k = 0; k < 3; k++) begin
      tick;
      check("post_rst_vld", outValid, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end
endmodule

// File: doc/imm_extend_pipe.md
# imm_extend_pipe

Parametrised, pipelined immediate-extension unit for the MIPS datapath. Converts an IN_W-bit instruction immediate into an OUT_W-bit operand in one of four modes: zero-extend, sign-extend, upper-load (LUI) and branch-offset. Results go into a DEPTH-entry output buffer with valid/ready handshakes on both sides, so decode can run ahead of a stalled execute stage. It replaces the combinational single-mode extender between decode and the ALU/branch-target adder.

## Interface
- IN_W, 16, immediate width; IN_W ≥ 2.
- OUT_W, 32, result width; OUT_W ≥ IN_W + BR_SHIFT.
- BR_SHIFT, 2, left shift applied in branch-offset mode; 0 ≤ BR_SHIFT ≤ OUT_W − IN_W.
- DEPTH, 2, output buffer entries; power of two, ≥ 2.

Ports:
- clk  in  1  rising-edge clock; the block's only clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream presents an immediate.
- in_ready  out  1  block can accept this cycle.
- in_imm  in  IN_W  raw immediate.
- in_mode  in  2  extension mode: 00 zero, 01 sign, 10 upper, 11 branch.
- out_valid  out  1  buffer head holds a result.
- out_ready  in  1  downstream consumes the head this cycle.
- out_data  out  OUT_W  extended result at the buffer head.
- out_count  out  $clog2(DEPTH)+1  current buffer occupancy.

## Operation
- Bit-exact extension, with imm = in_imm:
  - 00 zero: result[i] = imm[i] for i < IN_W; all upper bits 0.
  - 01 sign: result[i] = imm[i] for i < IN_W; bits ≥ IN_W equal imm[IN_W−1].
  - 10 upper: result[OUT_W−1 : OUT_W−IN_W] = imm; all lower bits 0.
  - 11 branch: sign-extend as in 01, then shift left by BR_SHIFT; vacated low bits 0.
- Every output bit maps from exactly one input bit or a constant. No cross-wiring between bit positions; each bit is checked individually.
- Extension is combinational on the accept path. The result is written into the buffer, never held in an intermediate register.
- Buffer is a circular FIFO with write pointer, read pointer and count. Pointers wrap modulo DEPTH.
- Push = in_valid & in_ready. Pop = out_valid & out_ready.
- in_ready = (count < DEPTH) & rst_n. It depends only on registered state, with no combinational path from out_ready.
- out_valid = (count != 0). out_data = entry at the read pointer. out_count = count.
- Simultaneous push and pop with 0 < count < DEPTH: both happen, count is unchanged, order is preserved.
- Full (count = DEPTH): in_ready = 0, so a push and pop in the same cycle cannot both occur. The pop frees one slot for the next cycle.
- Empty: out_valid = 0. out_data holds the stale head and is don't-care, but must not be X after the first write.
- Reset asserted mid-operation clears count and pointers immediately. In-flight entries are discarded, never emitted.

## Timing
- Reset values: in_ready 0 while rst_n low, 1 from the first cycle after deassertion. out_valid 0, out_count 0, out_data 0, all buffer entries 0.
- Latency: an immediate accepted at edge N appears on out_data with out_valid = 1 after edge N (usable in cycle N+1) when the buffer was empty.
- Throughput: one result per cycle sustained while out_ready = 1.
- Full recovery: a pop at edge N raises in_ready in cycle N+1.
- out_data and out_valid change only on clk edges or on rst_n assertion.
- Upstream may hold in_valid across in_ready = 0. Inputs are sampled only on the accepting edge.

## Test plan
- Reset and idle: hold rst_n low, then release → in_ready 0 during reset and 1 after, out_valid 0, out_count 0, out_data 0.
- Mode coverage (defaults): push 0x8001 with modes 00/01/10/11 and out_ready = 1 → 0x00008001, 0xFFFF8001, 0x80010000, 0xFFFE0004, one per cycle.
- Bit isolation: push 0x0100 (mode 00), then 0x0040 (mode 00), then 0x7FFF (mode 01) → 0x00000100, 0x00000040, 0x00007FFF; bits 8 and 6 never aliased.
- Backpressure/full: out_ready = 0, push 3 values → first two accepted, in_ready 0 with out_count 2. Raise out_ready → values emerge in order, and the third is accepted the cycle after the first pop.
- Streaming with simultaneous push and pop: 100 random immediates/modes with random out_ready → output sequence matches a reference model, no loss or duplication, out_count never exceeds 2.
- Reset mid-stream: with 2 entries buffered, pulse rst_n low → out_valid drops immediately, and no old data appears after release. Also rerun mode coverage with IN_W = 8, OUT_W = 16, BR_SHIFT = 1, DEPTH = 4: 0x81 in mode 11 → 0xFF02.
